// File: rtl/uart_cmd_responder_if.sv
// uart_cmd_responder_if: RX/TX FIFO, register bus and status signals of the command responder
interface uart_cmd_responder_if;
  logic        i_rx_fifo_empty;
  logic [39:0] i_rx_fifo_data;
  logic        o_rx_fifo_re;
  logic        i_tx_fifo_full;
  logic        o_tx_fifo_we;
  logic [39:0] o_tx_fifo_data;
  logic [15:0] o_reg_addr;
  logic [15:0] o_reg_wdata;
  logic        o_reg_we;
  logic        o_reg_re;
  logic [15:0] i_reg_rdata;
  logic        i_reg_rvalid;
  logic        o_busy;
  logic [7:0]  o_err_count;
  modport slave (
    input  i_rx_fifo_empty, i_rx_fifo_data, i_tx_fifo_full, i_reg_rdata, i_reg_rvalid,
    output o_rx_fifo_re, o_tx_fifo_we, o_tx_fifo_data, o_reg_addr, o_reg_wdata,
           o_reg_we, o_reg_re, o_busy, o_err_count
  );
  modport master (
    output i_rx_fifo_empty, i_rx_fifo_data, i_tx_fifo_full, i_reg_rdata, i_reg_rvalid,
    input  o_rx_fifo_re, o_tx_fifo_we, o_tx_fifo_data, o_reg_addr, o_reg_wdata,
           o_reg_we, o_reg_re, o_busy, o_err_count
  );
endinterface

// File: rtl/uart_cmd_responder.sv
// uart_cmd_responder: decodes 40-bit RX frames into register writes/reads/pings and pushes responses
// Define UART_CMD_WRITE_ACK_EN to make every WRITE return an 8'h81 echo frame.
module uart_cmd_responder #(
  parameter int READ_TIMEOUT = 1000,
  parameter int CNT_W        = 10
) (
  input logic           clk,
  input logic           rst,
  uart_cmd_responder_if.slave bus
);
`ifdef UART_CMD_WRITE_ACK_EN
  localparam bit WR_ACK = 1'b1;
`else
  localparam bit WR_ACK = 1'b0;
`endif
  localparam logic [7:0] OP_WR = 8'h01, OP_RD = 8'h02, OP_PING = 8'h03;
  typedef enum logic [2:0] {S_IDLE, S_POP, S_DECODE, S_READ_WAIT, S_RESP} state_t;
  state_t           r_state, w_next;
  logic [39:0]      r_frame, r_tx_data, w_resp;
  logic [15:0]      r_addr, r_wdata;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_err;
  logic             r_tx_we;
  logic             w_rx_re, w_reg_we, w_reg_re, w_tx_push, w_err_inc, w_load;
  logic [7:0]       w_op, w_rx_op;
  logic             w_is_wr, w_is_rd, w_is_ping, w_timeout;
  assign w_op      = r_frame[39:32];
  assign w_rx_op   = bus.i_rx_fifo_data[39:32];
  assign w_is_wr   = w_op == OP_WR;
  assign w_is_rd   = w_op == OP_RD;
  assign w_is_ping = w_op == OP_PING;
  assign w_timeout = r_cnt == CNT_W'(READ_TIMEOUT - 1);
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      w_next = bus.i_rx_fifo_empty ? S_IDLE : S_POP;
      S_POP:       w_next = S_DECODE;
      S_DECODE:    w_next = w_is_rd ? S_READ_WAIT : (w_is_wr && !WR_ACK) ? S_IDLE : S_RESP;
      S_READ_WAIT: w_next = (bus.i_reg_rvalid || w_timeout) ? S_RESP : S_READ_WAIT;
      S_RESP:      w_next = bus.i_tx_fifo_full ? S_RESP : S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end
  // Response frame is captured on the transition into RESP so it stays stable while stalled
  always_comb begin
    w_rx_re   = r_state == S_IDLE && !bus.i_rx_fifo_empty;
    w_reg_we  = r_state == S_DECODE && w_is_wr;
    w_reg_re  = r_state == S_DECODE && w_is_rd;
    w_tx_push = r_state == S_RESP && !bus.i_tx_fifo_full;
    w_err_inc = (r_state == S_DECODE && !w_is_wr && !w_is_rd && !w_is_ping) ||
                (r_state == S_READ_WAIT && !bus.i_reg_rvalid && w_timeout);
    w_load    = w_next == S_RESP && r_state != S_RESP;
    w_resp    = r_state == S_READ_WAIT ?
                  (bus.i_reg_rvalid ? {8'h82, r_frame[31:16], bus.i_reg_rdata}
                                    : {8'hE2, r_frame[31:16], 16'hDEAD}) :
                w_is_wr   ? {8'h81, r_frame[31:0]} :
                w_is_ping ? {8'h83, r_frame[31:0]} :
                            {8'hEE, r_frame[31:16], 8'h00, w_op};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame   <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_tx_data <= '0;
      r_tx_we   <= 1'b0;
      r_cnt     <= '0;
      r_err     <= '0;
    end else begin
      r_tx_we <= w_tx_push;
      r_cnt   <= r_state == S_READ_WAIT ? r_cnt + 1'b1 : '0;
      if (r_state == S_POP) begin
        r_frame <= bus.i_rx_fifo_data;
        if (w_rx_op == OP_WR || w_rx_op == OP_RD) r_addr <= bus.i_rx_fifo_data[31:16];
        if (w_rx_op == OP_WR) r_wdata <= bus.i_rx_fifo_data[15:0];
      end
      if (w_load) r_tx_data <= w_resp;
      if (w_err_inc && r_err != 8'hFF) r_err <= r_err + 1'b1;
    end
  end
  assign bus.o_rx_fifo_re   = w_rx_re;
  assign bus.o_tx_fifo_we   = r_tx_we;
  assign bus.o_tx_fifo_data = r_tx_data;
  assign bus.o_reg_addr     = r_addr;
  assign bus.o_reg_wdata    = r_wdata;
  assign bus.o_reg_we       = w_reg_we;
  assign bus.o_reg_re       = w_reg_re;
  assign bus.o_busy         = r_state != S_IDLE;
  assign bus.o_err_count    = r_err;
endmodule

// File: tb/tb_uart_cmd_responder.sv
// tb_uart_cmd_responder: table-driven vectors plus hand sequences, TX frames checked via a scoreboard queue
module tb_uart_cmd_responder;
  localparam int READ_TIMEOUT = 1000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  uart_cmd_responder_if bus();
  uart_cmd_responder #(.READ_TIMEOUT(READ_TIMEOUT), .CNT_W(10)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  int checks = 0, errors = 0;
  int cyc = 0, re_cnt = 0, re_cyc = 0, we_cnt = 0, we_cyc = 0, wr_cnt = 0;
  logic [15:0] wr_addr, wr_data;
  logic [39:0] sb[$];
  logic [39:0] rx_mem [0:2047];
  int wp = 0, rp = 0;
  assign bus.i_rx_fifo_empty = (wp == rp);
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.o_rx_fifo_re && wp != rp) begin
      bus.i_rx_fifo_data <= rx_mem[11'(rp)];
      rp <= rp + 1;
    end
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_rx_fifo_re) begin re_cnt++; re_cyc = cyc; end
      if (bus.o_reg_we) begin wr_cnt++; wr_addr = bus.o_reg_addr; wr_data = bus.o_reg_wdata; end
      if (bus.o_tx_fifo_we) begin
        we_cnt++;
        we_cyc = cyc;
        if (sb.size() == 0) chk("tx_unexpected", 64'(bus.o_tx_fifo_data), 64'hFFFF_FFFF_FFFF_FFFF);
        else chk("tx_frame", 64'(bus.o_tx_fifo_data), 64'(sb.pop_front()));
      end
    end
  end
  task automatic push(input logic [39:0] f);
    @(posedge clk); #1;
    rx_mem[11'(wp)] = f;
    wp++;
  endtask
  task automatic wait_idle(input int lim);
    int n = 0;
    @(negedge clk);
    while ((bus.o_busy || !bus.i_rx_fifo_empty) && n < lim) begin @(negedge clk); n++; end
    chk("idle_reached", 64'(n < lim), 64'd1);
    @(negedge clk);
  endtask
  typedef struct {
    logic [39:0] frame;
    int          dly;
    logic [15:0] rdata;
    bit          resp;
    logic [39:0] tx;
    logic [7:0]  err;
    bit          lat;
  } vec_t;
  task automatic run_vec(input vec_t t);
    int re0 = re_cnt, we0 = we_cnt, wr0 = wr_cnt, n = 0;
    if (t.resp) sb.push_back(t.tx);
    push(t.frame);
    if (t.frame[39:32] == 8'h02) begin
      while (!bus.o_reg_re && n < 20) begin @(negedge clk); n++; end
      chk("rd_strobe", 64'(n < 20), 64'd1);
      chk("rd_addr", 64'(bus.o_reg_addr), 64'(t.frame[31:16]));
      if (t.dly >= 0) begin
        repeat (t.dly) @(negedge clk);
        bus.i_reg_rvalid = 1'b1;
        bus.i_reg_rdata  = t.rdata;
        @(negedge clk);
        bus.i_reg_rvalid = 1'b0;
      end
    end
    wait_idle(3000);
    chk("pop_once", 64'(re_cnt - re0), 64'd1);
    chk("resp_count", 64'(we_cnt - we0), 64'(t.resp));
    chk("err_count", 64'(bus.o_err_count), 64'(t.err));
    if (t.lat) chk("ping_latency", 64'(we_cyc - re_cyc), 64'd4);
    if (t.frame[39:32] == 8'h01) begin
      chk("wr_strobe", 64'(wr_cnt - wr0), 64'd1);
      chk("wr_addr", 64'(wr_addr), 64'(t.frame[31:16]));
      chk("wr_data", 64'(wr_data), 64'(t.frame[15:0]));
    end
  endtask
  vec_t v[8];
  bit ack;
  initial begin
    int re0, we0;
`ifdef UART_CMD_WRITE_ACK_EN
    ack = 1'b1;
`else
    ack = 1'b0;
`endif
    v[0] = '{40'h03_1234_5678, -1, 16'h0,    1'b1, 40'h83_1234_5678, 8'd0, 1'b1};
    v[1] = '{40'h01_0010_BEEF, -1, 16'h0,    ack,  40'h81_0010_BEEF, 8'd0, 1'b0};
    v[2] = '{40'h02_0020_0000,  5, 16'hCAFE, 1'b1, 40'h82_0020_CAFE, 8'd0, 1'b0};
    v[3] = '{40'h02_0020_0000, -1, 16'h0,    1'b1, 40'hE2_0020_DEAD, 8'd1, 1'b0};
    v[4] = '{40'h02_0020_0000, READ_TIMEOUT, 16'h1234, 1'b1, 40'h82_0020_1234, 8'd1, 1'b0};
    v[5] = '{40'h00_ABCD_1111, -1, 16'h0,    1'b1, 40'hEE_ABCD_0000, 8'd2, 1'b0};
    v[6] = '{40'hFF_0001_2222, -1, 16'h0,    1'b1, 40'hEE_0001_00FF, 8'd3, 1'b0};
    v[7] = '{40'h01_0040_1234, -1, 16'h0,    ack,  40'h81_0040_1234, 8'd3, 1'b0};
    bus.i_tx_fifo_full = 1'b0;
    bus.i_reg_rvalid   = 1'b0;
    bus.i_reg_rdata    = '0;
    repeat (3) @(negedge clk);
    chk("rst_re", 64'(bus.o_rx_fifo_re), 64'd0);
    chk("rst_we", 64'(bus.o_tx_fifo_we), 64'd0);
    chk("rst_txd", 64'(bus.o_tx_fifo_data), 64'd0);
    chk("rst_addr", 64'(bus.o_reg_addr), 64'd0);
    chk("rst_wdata", 64'(bus.o_reg_wdata), 64'd0);
    chk("rst_strobes", 64'({bus.o_reg_we, bus.o_reg_re}), 64'd0);
    chk("rst_busy", 64'(bus.o_busy), 64'd0);
    chk("rst_err", 64'(bus.o_err_count), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) run_vec(v[i]);
    chk("addr_hold", 64'({bus.o_reg_addr, bus.o_reg_wdata}), 64'h0040_1234);
    // Rvalid while idle must not provoke anything
    bus.i_reg_rvalid = 1'b1;
    repeat (3) @(negedge clk);
    bus.i_reg_rvalid = 1'b0;
    chk("rvalid_idle_busy", 64'(bus.o_busy), 64'd0);
    // Unknown opcode stalled by a full TX FIFO with a second frame queued
    re0 = re_cnt; we0 = we_cnt;
    bus.i_tx_fifo_full = 1'b1;
    sb.push_back(40'hEE_0030_007F);
    sb.push_back(40'h83_AAAA_BBBB);
    push(40'h7F_0030_0000);
    push(40'h03_AAAA_BBBB);
    repeat (20) @(negedge clk);
    chk("full_no_we", 64'(we_cnt - we0), 64'd0);
    chk("full_no_second_re", 64'(re_cnt - re0), 64'd1);
    chk("full_busy", 64'(bus.o_busy), 64'd1);
    chk("full_hold_frame", 64'(bus.o_tx_fifo_data), 64'h00EE_0030_007F);
    bus.i_tx_fifo_full = 1'b0;
    wait_idle(100);
    chk("full_err", 64'(bus.o_err_count), 64'd4);
    chk("full_pops", 64'(re_cnt - re0), 64'd2);
    chk("full_pushes", 64'(we_cnt - we0), 64'd2);
    // Reset in READ_WAIT drops the frame without a response
    we0 = we_cnt;
    push(40'h02_0050_0000);
    begin
      int n = 0;
      while (!bus.o_reg_re && n < 20) begin @(negedge clk); n++; end
      chk("rst_rd_strobe", 64'(n < 20), 64'd1);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rrst_outs", 64'({bus.o_rx_fifo_re, bus.o_tx_fifo_we, bus.o_reg_we, bus.o_reg_re, bus.o_busy}), 64'd0);
    chk("rrst_txd", 64'(bus.o_tx_fifo_data), 64'd0);
    chk("rrst_addr", 64'({bus.o_reg_addr, bus.o_reg_wdata}), 64'd0);
    chk("rrst_err", 64'(bus.o_err_count), 64'd0);
    rst = 1'b0;
    bus.i_reg_rvalid = 1'b1;
    bus.i_reg_rdata  = 16'h5555;
    @(negedge clk);
    bus.i_reg_rvalid = 1'b0;
    repeat (5) @(negedge clk);
    chk("rrst_no_resp", 64'(we_cnt - we0), 64'd0);
    run_vec('{40'h03_0102_0304, -1, 16'h0, 1'b1, 40'h83_0102_0304, 8'd0, 1'b1});
    // Err_Count saturation
    for (int i = 0; i < 300; i++) begin
      sb.push_back({8'hEE, 16'(i), 8'h00, 8'h10});
      push({8'h10, 16'(i), 16'h0});
    end
    wait_idle(4000);
    chk("err_saturate", 64'(bus.o_err_count), 64'hFF);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
